// File: rtl/mult_sched_pkg.sv
// Shared types and default sizing for the multiplier round-robin scheduler.
// Tag and credit widths follow the default configuration below.
package mult_sched_pkg;
  localparam int DEF_XLEN      = 32;
  localparam int DEF_NUM_STAGE = 4;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_OUT   = 2;

  localparam int ID_W   = $clog2(DEF_NUM_REQ);
  localparam int CRED_W = $clog2(DEF_MAX_OUT + 1);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } mult_tag_t;

  typedef struct packed {
    logic [1:0]          sign;
    logic [DEF_XLEN-1:0] mcand;
    logic [DEF_XLEN-1:0] mplier;
  } mult_op_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from pointer+1 with an explicit
// wrap compare so non-power-of-two requester counts rotate correctly.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = pointer;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      if (!grant_valid && eligible[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one fixed-latency pipelined multiplier among NUM_REQ requesters with
// round-robin issue, per-requester credits and a tag pipe for product routing.
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int NUM_STAGE = DEF_NUM_STAGE,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_OUT   = DEF_MAX_OUT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*2-1:0]   req_sign,
  input  logic [NUM_REQ*XLEN-1:0] req_mcand,
  input  logic [NUM_REQ*XLEN-1:0] req_mplier,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [2*XLEN-1:0]      rsp_product,
  output logic                   mult_start,
  output logic [1:0]             mult_sign,
  output logic [XLEN-1:0]        mult_mcand,
  output logic [XLEN-1:0]        mult_mplier,
  input  logic [2*XLEN-1:0]      mult_product,
  input  logic                   mult_done,
  output logic                   tag_err
);

  localparam int LAST = NUM_STAGE - 1;

  mult_tag_t          tag_q [NUM_STAGE];
  mult_op_t           op_q;
  mult_op_t           sel_op;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    issue_id_q;
  logic [ID_W-1:0]    grant_idx;
  logic [CRED_W-1:0]  credit_q [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] underflow;
  logic               grant_valid;
  logic               mult_start_q;
  logic               tag_err_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (credit_q[i] < CRED_W'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .eligible    (eligible),
    .pointer     (ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = reset_n ? grant : '0;

  always_comb begin
    sel_op.sign   = req_sign[grant_idx*2 +: 2];
    sel_op.mcand  = req_mcand[grant_idx*XLEN +: XLEN];
    sel_op.mplier = req_mplier[grant_idx*XLEN +: XLEN];
  end

  // The last tag stage lines up with mult_done, so it names the owner of mult_product.
  always_comb begin
    rsp_valid = '0;
    if (reset_n && tag_q[LAST].valid) begin
      rsp_valid[tag_q[LAST].id] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      underflow[i] = rsp_valid[i] && (credit_q[i] == '0);
    end
  end

  assign rsp_product = mult_product;
  assign mult_start  = mult_start_q;
  assign mult_sign   = op_q.sign;
  assign mult_mcand  = op_q.mcand;
  assign mult_mplier = op_q.mplier;
  assign tag_err     = tag_err_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mult_start_q <= 1'b0;
      op_q         <= '0;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      issue_id_q   <= '0;
      tag_err_q    <= 1'b0;
      for (int s = 0; s < NUM_STAGE; s++) tag_q[s] <= '0;
      for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= '0;
    end else begin
      mult_start_q <= grant_valid;
      if (grant_valid) begin
        op_q       <= sel_op;
        ptr_q      <= grant_idx;
        issue_id_q <= grant_idx;
      end
      tag_q[0] <= '{valid: mult_start_q, id: issue_id_q};
      for (int s = 1; s < NUM_STAGE; s++) tag_q[s] <= tag_q[s-1];
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({req_ready[i], rsp_valid[i]})
          2'b10:   credit_q[i] <= credit_q[i] + 1'b1;
          2'b01:   if (credit_q[i] != '0) credit_q[i] <= credit_q[i] - 1'b1;
          default: credit_q[i] <= credit_q[i];
        endcase
      end
      if ((mult_done != tag_q[LAST].valid) || (|underflow)) tag_err_q <= 1'b1;
    end
  end

endmodule
